iter_shifter: RTL and testbench



---
 rtl/iter_shifter_pkg.sv | 20 ++
 rtl/iter_shifter_shift_step.sv | 38 +++
 rtl/iter_shifter.sv | 84 ++++++++
 tb/tb_iter_shifter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iter_shifter_pkg.sv
// iter_shifter shared definitions: op and state encodings, step limit.
// Imported by the one-step shifter and the iterating top level.
package iter_shifter_pkg;

   typedef enum logic [1:0] {
      OP_LSL = 2'b00,
      OP_LSR = 2'b01,
      OP_ASR = 2'b10,
      OP_ROR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

   localparam int STEP_MAX = 3;

endpackage

// File: rtl/iter_shifter_shift_step.sv
// Combinational one-step shifter: shifts d by step (0..3) under op.
// Ports: d (WIDTH), op, step (2) -> q (WIDTH).
module iter_shifter_shift_step
   import iter_shifter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] d,
   input  op_e              op,
   input  logic [1:0]       step,
   output logic [WIDTH-1:0] q
);

   // One 4:1 mux per bit; candidate k is the bit shifted by k.
   // Only edge bits need an op-dependent fill source.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [3:0] cand;
      assign cand[0] = d[i];
      for (genvar k = 1; k < 4; k++) begin : g_k
         logic l;
         logic r;
         if (i >= k) begin : g_l
            assign l = d[i-k];
         end else begin : g_lz
            assign l = 1'b0;
         end
         if (i + k < WIDTH) begin : g_r
            assign r = d[i+k];
         end else begin : g_rf
            assign r = (op == OP_ROR) ? d[i+k-WIDTH] :
                       (op == OP_ASR) ? d[WIDTH-1]   : 1'b0;
         end
         assign cand[k] = (op == OP_LSL) ? l : r;
      end
      assign q[i] = cand[step];
   end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle barrel shifter: LSL/LSR/ASR/ROR by 0..WIDTH-1, up to 3 per cycle.
// Ports: clk, reset_n, start, op, shamt, d_in -> d_out, busy, done.
module iter_shifter
   import iter_shifter_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int SW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [SW-1:0]    shamt,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] d_out,
   output logic             busy,
   output logic             done
);

   state_e          state;
   op_e             op_q;
   logic [SW-1:0]   rem;
   logic [1:0]      step;
   logic [WIDTH-1:0] stepped;

   // step = min(rem, STEP_MAX); never exceeds rem, so rem cannot underflow
   assign step = (rem > SW'(STEP_MAX)) ? 2'(STEP_MAX) : rem[1:0];

   iter_shifter_shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .d    (d_out),
      .op   (op_q),
      .step (step),
      .q    (stepped)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         op_q  <= OP_LSL;
         rem   <= '0;
         d_out <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  d_out <= d_in;
                  op_q  <= op_e'(op);
                  rem   <= shamt;
                  busy  <= 1'b1;
                  if (shamt == '0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_SHIFT;
                  end
               end
            end
            ST_SHIFT: begin
               d_out <= stepped;
               rem   <= rem - SW'(step);
               if (rem == SW'(step)) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iter_shifter.sv
// Randomised scoreboard bench for iter_shifter (WIDTH=32 and WIDTH=8).
// Driver pushes expected result and done cycle; monitors pop on done.
module tb_iter_shifter;

   typedef struct {
      logic [31:0] exp;
      int          due;
      int          sh;
   } item_t;

   logic        clk = 0;
   logic        reset_n = 0;

   logic        start32 = 0;
   logic [1:0]  op32 = 0;
   logic [4:0]  sh32 = 0;
   logic [31:0] din32 = 0;
   logic [31:0] dout32;
   logic        busy32;
   logic        done32;

   logic        start8 = 0;
   logic [1:0]  op8 = 0;
   logic [2:0]  sh8 = 0;
   logic [7:0]  din8 = 0;
   logic [7:0]  dout8;
   logic        busy8;
   logic        done8;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   item_t q32[$];
   item_t q8[$];
   int bcnt32 = 0;
   int bcnt8 = 0;

   iter_shifter #(.WIDTH(32)) dut32 (
      .clk(clk), .reset_n(reset_n), .start(start32), .op(op32),
      .shamt(sh32), .d_in(din32), .d_out(dout32), .busy(busy32),
      .done(done32)
   );

   iter_shifter #(.WIDTH(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .start(start8), .op(op8),
      .shamt(sh8), .d_in(din8), .d_out(dout8), .busy(busy8),
      .done(done8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Reference model: whole-amount shifts in plain arithmetic
   function automatic logic [31:0] m32(int op, logic [31:0] d, int sh);
      case (op)
         0: return d << sh;
         1: return d >> sh;
         2: return $signed(d) >>> sh;
         default: return (d >> sh) | (d << (32 - sh));
      endcase
   endfunction

   function automatic logic [7:0] m8(int op, logic [7:0] d, int sh);
      case (op)
         0: return d << sh;
         1: return d >> sh;
         2: return $signed(d) >>> sh;
         default: return (d >> sh) | (d << (8 - sh));
      endcase
   endfunction

   // Monitors
   always @(negedge clk) begin
      if (!reset_n) begin
         q32.delete();
         bcnt32 = 0;
      end else begin
         if (busy32) bcnt32++;
         if (done32) begin
            if (q32.size() == 0) begin
               check("done32_unexpected", 32'd1, 32'd0);
            end else begin
               item_t it;
               it = q32.pop_front();
               check("dout32", dout32, it.exp);
               check("lat32", cyc, it.due);
               check("busy_len32", bcnt32, (it.sh + 2) / 3 + 1);
            end
            bcnt32 = 0;
         end else if (q32.size() != 0 && cyc > q32[0].due + 3) begin
            check("timeout32", 32'd0, 32'd1);
            void'(q32.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!reset_n) begin
         q8.delete();
         bcnt8 = 0;
      end else begin
         if (busy8) bcnt8++;
         if (done8) begin
            if (q8.size() == 0) begin
               check("done8_unexpected", 32'd1, 32'd0);
            end else begin
               item_t it;
               it = q8.pop_front();
               check("dout8", {24'd0, dout8}, it.exp);
               check("lat8", cyc, it.due);
               check("busy_len8", bcnt8, (it.sh + 2) / 3 + 1);
            end
            bcnt8 = 0;
         end else if (q8.size() != 0 && cyc > q8[0].due + 3) begin
            check("timeout8", 32'd0, 32'd1);
            void'(q8.pop_front());
         end
      end
   end

   task automatic wait_idle32();
      int n = 0;
      @(negedge clk);
      while (busy32 !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("idle_wait32", 32'd0, 32'd1);
   endtask

   task automatic issue32(int op, logic [31:0] d, int sh, bit junk);
      item_t it;
      wait_idle32();
      start32 = 1;
      op32 = 2'(op);
      sh32 = 5'(sh);
      din32 = d;
      it.exp = m32(op, d, sh);
      it.due = cyc + 1 + (sh + 2) / 3;
      it.sh = sh;
      q32.push_back(it);
      @(posedge clk);
      #1;
      start32 = 0;
      op32 = 2'($urandom);
      sh32 = 5'($urandom);
      din32 = $urandom;
      if (junk) begin
         @(negedge clk);
         if (busy32) begin
            start32 = 1;
            din32 = $urandom;
            @(posedge clk);
            #1;
            start32 = 0;
         end
      end
   endtask

   task automatic issue8(int op, logic [7:0] d, int sh);
      item_t it;
      int n = 0;
      @(negedge clk);
      while (busy8 !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("idle_wait8", 32'd0, 32'd1);
      start8 = 1;
      op8 = 2'(op);
      sh8 = 3'(sh);
      din8 = d;
      it.exp = {24'd0, m8(op, d, sh)};
      it.due = cyc + 1 + (sh + 2) / 3;
      it.sh = sh;
      q8.push_back(it);
      @(posedge clk);
      #1;
      start8 = 0;
      din8 = 8'($urandom);
      sh8 = 3'($urandom);
   endtask

   initial begin
      int n;
      #12;
      check("rst_dout32", dout32, 32'd0);
      check("rst_busy32", {31'd0, busy32}, 32'd0);
      check("rst_done32", {31'd0, done32}, 32'd0);
      check("rst_dout8", {24'd0, dout8}, 32'd0);
      @(negedge clk);
      reset_n = 1;

      issue32(2, 32'h8000_0000, 4, 0);
      issue32(1, 32'h8000_0000, 4, 0);
      issue32(0, 32'h0000_00FF, 8, 0);
      issue32(3, 32'h0000_0001, 31, 0);
      issue32(2, 32'h1234_5678, 0, 1);
      issue32(2, 32'h8765_4321, 30, 1);
      for (int i = 0; i < 150; i++)
         issue32($urandom_range(0, 3), $urandom,
                 $urandom_range(0, 31), $urandom_range(0, 1) == 1);

      // asynchronous reset in the third SHIFT cycle of ASR by 20
      wait_idle32();
      start32 = 1;
      op32 = 2'd2;
      sh32 = 5'd20;
      din32 = 32'hC0DE_F00D;
      @(posedge clk);
      #1;
      start32 = 0;
      @(posedge clk);
      @(posedge clk);
      #2;
      reset_n = 0;
      #1;
      check("async_dout", dout32, 32'd0);
      check("async_busy", {31'd0, busy32}, 32'd0);
      check("async_done", {31'd0, done32}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1;
      issue32(0, 32'h1, 1, 0);

      issue8(2, 8'h90, 7);
      issue8(3, 8'h81, 1);
      for (int i = 0; i < 60; i++)
         issue8($urandom_range(0, 3), 8'($urandom), $urandom_range(0, 7));

      n = 0;
      while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("drain", 32'd0, 32'd1);
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
